fifo2_drain_serializer: RTL
===========================

// Module: fifo2_drain_serializer
// PURPOSE
//  Consumer for the deq side of a guarded-method FIFO (first/deq/RDY/ENA).
//  Pulls one packed WORDS*DW entry per deq, replays it as WORDS DW-bit words
//  on a downstream guarded enq interface, lowest word first.
//  Sits between a Fifo2-style buffer and a narrow DW-bit sink.
// PARAMETERS
//  DW     32  width of one output word
//  WORDS  3   words per FIFO entry; entry width = WORDS*DW (96 by default)
// PORTS
//  CLK            in   1         clock, all state on posedge
//  RST            in   1         synchronous, active-high reset
//  in$first       in   WORDS*DW  head entry of upstream FIFO; word k = [k*DW +: DW]
//  in$first__RDY  in   1         in$first valid
//  in$deq__RDY    in   1         upstream deq may fire
//  in$deq__ENA    out  1         pop upstream head this cycle
//  out$enq$v      out  DW        word offered downstream
//  out$enq__ENA   out  1         enq fires this cycle
//  out$enq__RDY   in   1         downstream accepts
//  busy           out  1         entry held, words still pending
//  entries_done   out  32        count of fully emitted entries, wraps mod 2^32
// BEHAVIOUR
//  - Reset: state=IDLE, idx=0, hold=0, entries_done=0; so in$deq__ENA=0,
//    out$enq__ENA=0, out$enq$v=0, busy=0 in the cycle after RST is sampled.
//  - take = in$first__RDY & in$deq__RDY & (IDLE | last_fire);
//    in$deq__ENA = take & !RST (combinational; never fires during reset).
//  - On take: hold <= in$first, idx <= 0, state <= SEND. deq and capture are
//    the same cycle; first word offered the next cycle (latency 1).
//  - SEND: out$enq$v = hold[idx*DW +: DW]; out$enq__ENA = out$enq__RDY
//    (ENA only ever asserted with RDY, per guarded-method rule).
//  - fire = SEND & out$enq__RDY. On fire with idx<LAST: idx <= idx+1.
//    LAST = WORDS-1 (WORDS with checksum, below).
//  - last_fire = fire & idx==LAST: entries_done += 1; if take same cycle, reload
//    hold, idx<=0, stay SEND (back-to-back, WORDS words per WORDS cycles);
//    else state <= IDLE.
//  - RDY low in SEND: hold, idx, out$enq$v stable; no word skipped or repeated.
//  - IDLE: out$enq__ENA=0, out$enq$v holds last driven value (not checked).
//  - Upstream empty (in$first__RDY=0): stay IDLE, no deq.
//  - RST mid-entry: remaining words dropped, entry lost (already dequeued);
//    next deq no earlier than the cycle after RST deasserts.
//  - idx width = clog2(WORDS+1); entries_done 32-bit unsigned wrap.
//  - busy = (state==SEND).
// CONFIGURATION
//  FIFO2_DRAIN_CSUM_EN defined: an extra word follows the WORDS data words,
//    value = XOR of all WORDS words ^ DW'hA5A5_A5A5 (pattern truncated/repeated
//    to DW); LAST = WORDS; entries_done increments after the checksum word.
//  Undefined: no checksum word, LAST = WORDS-1; no checksum logic present.
// TESTING
//  1 Reset held 3 cycles, FIFO RDY=1 -> in$deq__ENA=0, out$enq__ENA=0, entries_done=0.
//  2 Entry {32'h3,32'h2,32'h1}, out RDY=1 -> deq@t0, words 1,2,3 at t1..t3,
//    entries_done=1 (CSUM_EN: 4th word 32'hA5A5A5A5^1^2^3=32'hA5A5A5A5).
//  3 Two entries queued, out RDY=1 -> second deq in cycle of 1st entry's last
//    word; 6 words in 6 consecutive cycles, no bubble.
//  4 out RDY toggled 1,0,0,1,1 on entry {C,B,A} -> A, stall 2 cycles stable at B,
//    then B, C; no extra enq fires.
//  5 RST asserted after 1st word of entry -> no further words, entries_done=0,
//    next entry emitted cleanly from word 0 after release.
//  6 entries_done preloaded via force to 32'hFFFF_FFFF, one entry -> wraps to 0.

Source files
------------

// File: rtl/fifo2_drain_serializer_if.sv
// Guarded-method bundle: upstream FIFO deq side (first/deq) plus the narrow downstream enq side.
interface fifo2_drain_serializer_if #(
    parameter int DW    = 32,
    parameter int WORDS = 3
);
    logic [WORDS*DW-1:0] in_first;
    logic                in_first_RDY;
    logic                in_deq_RDY;
    logic                in_deq_ENA;
    logic [DW-1:0]       out_enq_v;
    logic                out_enq_ENA;
    logic                out_enq_RDY;
    logic                busy;
    logic [31:0]         entries_done;

    modport master (
        input  in_first, in_first_RDY, in_deq_RDY, out_enq_RDY,
        output in_deq_ENA, out_enq_v, out_enq_ENA, busy, entries_done
    );

    modport slave (
        output in_first, in_first_RDY, in_deq_RDY, out_enq_RDY,
        input  in_deq_ENA, out_enq_v, out_enq_ENA, busy, entries_done
    );
endinterface

// File: rtl/fifo2_drain_serializer.sv
// Pops one WORDS*DW entry from a guarded FIFO and replays it as DW-bit words, lowest first.
// Optional FIFO2_DRAIN_CSUM_EN appends an XOR checksum word after the data words.
module fifo2_drain_serializer #(
    parameter int DW    = 32,
    parameter int WORDS = 3
) (
    input logic                      CLK,
    input logic                      RST,
    fifo2_drain_serializer_if.master bus
);
    localparam int ENT_W = WORDS * DW;
    localparam int IDX_W = $clog2(WORDS + 1);
`ifdef FIFO2_DRAIN_CSUM_EN
    localparam int LAST = WORDS;
`else
    localparam int LAST = WORDS - 1;
`endif

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [ENT_W-1:0]   hold;
    logic [31:0]        done_cnt;
    logic [DW-1:0]      cur_word;
    logic               fire;
    logic               last_fire;
    logic               take;

`ifdef FIFO2_DRAIN_CSUM_EN
    localparam int PAT_REP = (DW + 31) / 32;
    localparam logic [32*PAT_REP-1:0] PAT_WIDE = {PAT_REP{32'hA5A5_A5A5}};
    localparam logic [DW-1:0] CSUM_PAT = PAT_WIDE[DW-1:0];

    function automatic logic [DW-1:0] csum_word(input logic [ENT_W-1:0] e);
        logic [DW-1:0] acc;
        acc = CSUM_PAT;
        for (int k = 0; k < WORDS; k++) acc ^= DW'(e >> (k * DW));
        return acc;
    endfunction
`endif

    always_comb begin
        cur_word = '0;
        for (int k = 0; k < WORDS; k++)
            if (idx == IDX_W'(k)) cur_word = DW'(hold >> (k * DW));
`ifdef FIFO2_DRAIN_CSUM_EN
        if (idx == IDX_W'(WORDS)) cur_word = csum_word(hold);
`endif
    end

    assign fire      = (state == SEND) && bus.out_enq_RDY;
    assign last_fire = fire && (idx == IDX_W'(LAST));
    // A new entry may be captured while the previous entry's last word leaves.
    assign take      = bus.in_first_RDY && bus.in_deq_RDY && ((state == IDLE) || last_fire);

    assign bus.in_deq_ENA   = take && !RST;
    assign bus.out_enq_ENA  = fire;
    assign bus.out_enq_v    = cur_word;
    assign bus.busy         = (state == SEND);
    assign bus.entries_done = done_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            idx      <= '0;
            hold     <= '0;
            done_cnt <= '0;
        end else begin
            if (last_fire) done_cnt <= done_cnt + 32'd1;
            if (take) begin
                hold  <= bus.in_first;
                idx   <= '0;
                state <= SEND;
            end else if (last_fire) begin
                state <= IDLE;
            end else if (fire) begin
                idx <= idx + 1'b1;
            end
        end
    end
endmodule
